// File: rtl/adsr_envelope.sv
// Gated ADSR envelope generator that scales a signed 8-bit tone sample by the
// current envelope level. All state advances only on step_in ticks.
module adsr_envelope #(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             step_in,
  input  logic             gate_in,
  input  logic [7:0]       sample_in,
  input  logic [ACC_W-1:0] attack_rate_in,
  input  logic [ACC_W-1:0] decay_rate_in,
  input  logic [7:0]       sustain_level_in,
  input  logic [ACC_W-1:0] release_rate_in,
  output logic [7:0]       sample_out,
  output logic             valid_out,
  output logic [7:0]       level_out,
  output logic             active_out
);

  typedef enum logic [2:0] {StIdle, StAttack, StDecay, StSustain, StRelease} state_e;

  localparam logic [ACC_W-1:0] EnvMax = '1;

  state_e           r_state;
  logic [ACC_W-1:0] r_env;
  logic             r_gate_prev;

  state_e           w_state_sel;
  state_e           w_state_nxt;
  logic [ACC_W-1:0] w_env_nxt;
  logic [ACC_W-1:0] w_target;
  logic             w_rise;
  logic [ACC_W:0]   w_att_sum;
  logic [ACC_W:0]   w_dec_diff;
  logic [ACC_W:0]   w_rel_diff;
  logic [7:0]       w_level;
  logic signed [16:0] w_product;
  logic             w_unused_bits;

  assign w_target   = {sustain_level_in, {(ACC_W-8){1'b0}}};
  assign w_rise     = gate_in & ~r_gate_prev;
  assign w_level    = r_env[ACC_W-1 -: 8];
  // Extra MSB on each operation exposes carry-out / borrow.
  assign w_att_sum  = {1'b0, r_env} + {1'b0, attack_rate_in};
  assign w_dec_diff = {1'b0, r_env} - {1'b0, decay_rate_in};
  assign w_rel_diff = {1'b0, r_env} - {1'b0, release_rate_in};

  // Scale by the pre-update level; zero-extended level keeps the factor non-negative.
  assign w_product     = $signed(sample_in) * $signed({1'b0, w_level});
  assign w_unused_bits = ^{w_product[16], w_product[7:0]};

  // Gate-driven state selection, resolved before this step's arithmetic.
  always_comb begin
    w_state_sel = r_state;
    unique case (r_state)
      StIdle:                      if (w_rise)   w_state_sel = StAttack;
      StAttack, StDecay, StSustain: if (!gate_in) w_state_sel = StRelease;
      StRelease:                   if (w_rise)   w_state_sel = StAttack;
      default:                     w_state_sel = StIdle;
    endcase
  end

  // Envelope arithmetic of the selected state, including the automatic transitions.
  always_comb begin
    w_state_nxt = w_state_sel;
    w_env_nxt   = r_env;
    unique case (w_state_sel)
      StAttack: begin
        if ((attack_rate_in == '0) || w_att_sum[ACC_W] || (w_att_sum[ACC_W-1:0] == EnvMax)) begin
          w_env_nxt   = EnvMax;
          w_state_nxt = StDecay;
        end else begin
          w_env_nxt = w_att_sum[ACC_W-1:0];
        end
      end
      StDecay: begin
        // Also covers a target raised above env: the difference is then below target.
        if ((decay_rate_in == '0) || w_dec_diff[ACC_W] || (w_dec_diff[ACC_W-1:0] <= w_target)) begin
          w_env_nxt   = w_target;
          w_state_nxt = StSustain;
        end else begin
          w_env_nxt = w_dec_diff[ACC_W-1:0];
        end
      end
      StSustain: w_env_nxt = w_target;
      StRelease: begin
        if ((release_rate_in == '0) || w_rel_diff[ACC_W] || (w_rel_diff[ACC_W-1:0] == '0)) begin
          w_env_nxt   = '0;
          w_state_nxt = StIdle;
        end else begin
          w_env_nxt = w_rel_diff[ACC_W-1:0];
        end
      end
      default: w_env_nxt = '0;
    endcase
  end

  // FSM, envelope and registered sample output, all advancing on step ticks.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= StIdle;
      r_env       <= '0;
      r_gate_prev <= 1'b0;
      sample_out  <= 8'h00;
      valid_out   <= 1'b0;
    end else begin
      valid_out <= step_in;
      if (step_in) begin
        r_state     <= w_state_nxt;
        r_env       <= w_env_nxt;
        r_gate_prev <= gate_in;
        sample_out  <= w_product[15:8];
      end
    end
  end

  assign level_out  = w_level;
  assign active_out = (r_state != StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope; expected levels and samples are hand-computed.
module tb_adsr_envelope;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        step_in = 1'b0;
  logic        gate_in = 1'b0;
  logic [7:0]  sample_in = 8'h00;
  logic [15:0] attack_rate_in = 16'h0000;
  logic [15:0] decay_rate_in = 16'h0000;
  logic [7:0]  sustain_level_in = 8'h00;
  logic [15:0] release_rate_in = 16'h0000;
  logic [7:0]  sample_out;
  logic        valid_out;
  logic [7:0]  level_out;
  logic        active_out;

  int n_vec = 0;
  int n_err = 0;

  adsr_envelope #(.ACC_W(16)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .step_in         (step_in),
    .gate_in         (gate_in),
    .sample_in       (sample_in),
    .attack_rate_in  (attack_rate_in),
    .decay_rate_in   (decay_rate_in),
    .sustain_level_in(sustain_level_in),
    .release_rate_in (release_rate_in),
    .sample_out      (sample_out),
    .valid_out       (valid_out),
    .level_out       (level_out),
    .active_out      (active_out)
  );

  always #5 clk_in = ~clk_in;

  // One step pulse; returns at the following negedge with post-step outputs visible.
  task automatic step_once();
    @(negedge clk_in);
    step_in = 1'b1;
    @(negedge clk_in);
    step_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in  = 1'b0;
    step_in = 1'b0;
    gate_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      step_in = ~i[0];
      gate_in = ~i[0];
    end
    @(negedge clk_in);
    n_vec++; if (sample_out !== 8'h00) begin n_err++; $display("FAIL rst_sample: got %h want 00", sample_out); end
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    n_vec++; if (level_out !== 8'h00) begin n_err++; $display("FAIL rst_level: got %h want 00", level_out); end
    n_vec++; if (active_out !== 1'b0) begin n_err++; $display("FAIL rst_active: got %b want 0", active_out); end
    // Gate held high across reset release retriggers on the first step.
    step_in = 1'b0;
    gate_in = 1'b1;
    attack_rate_in = 16'h1000;
    rst_in = 1'b1;
    step_once();
    n_vec++; if (active_out !== 1'b1) begin n_err++; $display("FAIL rst_retrig_active: got %b want 1", active_out); end
    n_vec++; if (level_out !== 8'h10) begin n_err++; $display("FAIL rst_retrig_level: got %h want 10", level_out); end
  endtask

  task automatic test_full_adsr();
    do_reset();
    attack_rate_in = 16'h1000; decay_rate_in = 16'h0800;
    sustain_level_in = 8'h80; release_rate_in = 16'h2000;
    gate_in = 1'b1;
    repeat (15) step_once();
    n_vec++; if (level_out !== 8'hF0) begin n_err++; $display("FAIL atk15_level: got %h want f0", level_out); end
    step_once();
    n_vec++; if (level_out !== 8'hFF) begin n_err++; $display("FAIL atk16_level: got %h want ff", level_out); end
    repeat (15) step_once();
    // 0xFFFF - 15*0x800 = 0x87FF
    n_vec++; if (level_out !== 8'h87) begin n_err++; $display("FAIL dec15_level: got %h want 87", level_out); end
    step_once();
    n_vec++; if (level_out !== 8'h80) begin n_err++; $display("FAIL dec16_level: got %h want 80", level_out); end
    step_once();
    n_vec++; if (level_out !== 8'h80) begin n_err++; $display("FAIL sus_level: got %h want 80", level_out); end
    gate_in = 1'b0;
    repeat (3) step_once();
    n_vec++; if (level_out !== 8'h20) begin n_err++; $display("FAIL rel3_level: got %h want 20", level_out); end
    n_vec++; if (active_out !== 1'b1) begin n_err++; $display("FAIL rel3_active: got %b want 1", active_out); end
    step_once();
    n_vec++; if (level_out !== 8'h00) begin n_err++; $display("FAIL rel4_level: got %h want 00", level_out); end
    n_vec++; if (active_out !== 1'b0) begin n_err++; $display("FAIL rel4_active: got %b want 0", active_out); end
  endtask

  task automatic test_scaling();
    do_reset();
    attack_rate_in = 16'h0000; decay_rate_in = 16'h0001;
    sustain_level_in = 8'h80; release_rate_in = 16'h0000;
    gate_in = 1'b1;
    step_once();  // env = 0xFFFF
    sample_in = 8'h80;  // -128 at level 0xFF
    step_once();
    n_vec++; if (sample_out !== 8'h80) begin n_err++; $display("FAIL scale_m128: got %h want 80", sample_out); end
    n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL scale_valid_hi: got %b want 1", valid_out); end
    @(negedge clk_in);
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL scale_valid_lo: got %b want 0", valid_out); end
    sample_in = 8'h7F;  // 127 at level 0xFF
    step_once();
    n_vec++; if (sample_out !== 8'h7E) begin n_err++; $display("FAIL scale_p127: got %h want 7e", sample_out); end
    decay_rate_in = 16'h0000;  // instant clamp to 0x8000
    step_once();
    sample_in = 8'h40;  // 64 at level 0x80
    step_once();
    n_vec++; if (sample_out !== 8'h20) begin n_err++; $display("FAIL scale_64: got %h want 20", sample_out); end
    gate_in = 1'b0;
    step_once();  // release=0 -> idle, env 0
    sample_in = 8'h9C;  // -100 at level 0
    step_once();
    n_vec++; if (sample_out !== 8'h00) begin n_err++; $display("FAIL scale_lvl0: got %h want 00", sample_out); end
  endtask

  task automatic test_retrigger();
    do_reset();
    attack_rate_in = 16'h0000; decay_rate_in = 16'h9FFF;
    sustain_level_in = 8'h00; release_rate_in = 16'h1000;
    gate_in = 1'b1;
    step_once();  // 0xFFFF
    step_once();  // 0x6000, still decaying
    n_vec++; if (level_out !== 8'h60) begin n_err++; $display("FAIL retrig_dec_level: got %h want 60", level_out); end
    gate_in = 1'b0;
    step_once();
    step_once();  // 0x4000
    n_vec++; if (level_out !== 8'h40) begin n_err++; $display("FAIL retrig_rel_level: got %h want 40", level_out); end
    gate_in = 1'b1;
    attack_rate_in = 16'h0800;
    step_once();  // attack from 0x4000, not from 0
    n_vec++; if (level_out !== 8'h48) begin n_err++; $display("FAIL retrig_atk1_level: got %h want 48", level_out); end
    step_once();
    n_vec++; if (level_out !== 8'h50) begin n_err++; $display("FAIL retrig_atk2_level: got %h want 50", level_out); end
  endtask

  task automatic test_boundaries();
    do_reset();
    attack_rate_in = 16'h0000; decay_rate_in = 16'h6FFF;
    sustain_level_in = 8'h40; release_rate_in = 16'h0000;
    gate_in = 1'b1;
    step_once();
    n_vec++; if (level_out !== 8'hFF) begin n_err++; $display("FAIL bnd_atk0_level: got %h want ff", level_out); end
    step_once();  // 0x9000
    n_vec++; if (level_out !== 8'h90) begin n_err++; $display("FAIL bnd_dec_level: got %h want 90", level_out); end
    sustain_level_in = 8'hC0;
    decay_rate_in = 16'h0100;
    step_once();
    n_vec++; if (level_out !== 8'hC0) begin n_err++; $display("FAIL bnd_sus_raise: got %h want c0", level_out); end
    sustain_level_in = 8'hA0;  // sustain must track, decay would give 0xBF
    step_once();
    n_vec++; if (level_out !== 8'hA0) begin n_err++; $display("FAIL bnd_sus_track: got %h want a0", level_out); end
    gate_in = 1'b0;
    step_once();
    n_vec++; if (level_out !== 8'h00) begin n_err++; $display("FAIL bnd_rel0_level: got %h want 00", level_out); end
    n_vec++; if (active_out !== 1'b0) begin n_err++; $display("FAIL bnd_rel0_active: got %b want 0", active_out); end
  endtask

  task automatic test_tick_gating();
    int valid_seen;
    do_reset();
    attack_rate_in = 16'h1000;
    gate_in = 1'b1;
    step_once();
    valid_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      gate_in = ~gate_in;
      if (valid_out !== 1'b0) valid_seen++;
    end
    gate_in = 1'b1;
    n_vec++; if (valid_seen != 0) begin n_err++; $display("FAIL gating_valid: got %0d strobes want 0", valid_seen); end
    n_vec++; if (level_out !== 8'h10) begin n_err++; $display("FAIL gating_level: got %h want 10", level_out); end
    n_vec++; if (active_out !== 1'b1) begin n_err++; $display("FAIL gating_active: got %b want 1", active_out); end
    step_once();
    n_vec++; if (level_out !== 8'h20) begin n_err++; $display("FAIL gating_resume: got %h want 20", level_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_lvl;
    exp_lvl = 8'h20;
    @(negedge clk_in);
    step_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      exp_lvl = exp_lvl + 8'h10;
      n_vec++; if (level_out !== exp_lvl) begin n_err++; $display("FAIL b2b_level%0d: got %h want %h", i, level_out, exp_lvl); end
      n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b want 1", i, valid_out); end
    end
    step_in = 1'b0;
    @(negedge clk_in);
    n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL b2b_valid_end: got %b want 0", valid_out); end
    n_vec++; if (level_out !== 8'h50) begin n_err++; $display("FAIL b2b_level_end: got %h want 50", level_out); end
  endtask

  task automatic test_reset_mid_note();
    // Note is active at level 0x50; reset must drop it with no release tail.
    rst_in = 1'b0;
    @(negedge clk_in);
    n_vec++; if (active_out !== 1'b0) begin n_err++; $display("FAIL midrst_active: got %b want 0", active_out); end
    n_vec++; if (level_out !== 8'h00) begin n_err++; $display("FAIL midrst_level: got %h want 00", level_out); end
    rst_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_adsr();
    test_scaling();
    test_retrigger();
    test_boundaries();
    test_tick_gating();
    test_back_to_back();
    test_reset_mid_note();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
